// File: rtl/emulador_teclado.sv
// Keypad press emulator: drives a scanned 4x4 keypad interface as if a key were
// pressed, with contact bounce, a stable hold and a release pause per key code.
module emulador_teclado #(
    parameter int unsigned REBOTE_CICLOS  = 4,
    parameter int unsigned PRESION_CICLOS = 64,
    parameter int unsigned PAUSA_CICLOS   = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] cuenta_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic       key_ready_o,
    output logic [3:0] pulso_teclas_o,
    output logic [1:0] dato_codificador_o,
    output logic       ocupado_o,
    output logic       tecla_fin_o
);

    typedef enum logic [1:0] {LIBRE, REBOTE, PRESION, PAUSA} estado_t;

    localparam logic [15:0] REBOTE_FIN  = 16'(REBOTE_CICLOS - 1);
    localparam logic [15:0] PRESION_FIN = 16'(PRESION_CICLOS - 1);
    localparam logic [15:0] PAUSA_FIN   = 16'(PAUSA_CICLOS - 1);

    estado_t     estado_reg;
    logic [15:0] cnt_reg;
    logic [3:0]  code_reg;
    logic        fin_reg;

    logic       coincide;
    logic [3:0] fila;
    logic [3:0] pulso;

    // First state at or after 'desde' whose length is nonzero; LIBRE when all are skipped.
    function automatic estado_t primer_estado(input estado_t desde);
        estado_t r;
        r = LIBRE;
        if (desde == REBOTE && REBOTE_CICLOS != 0)
            r = REBOTE;
        else if ((desde == REBOTE || desde == PRESION) && PRESION_CICLOS != 0)
            r = PRESION;
        else if (desde != LIBRE && PAUSA_CICLOS != 0)
            r = PAUSA;
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            estado_reg <= LIBRE;
            cnt_reg    <= 16'd0;
            code_reg   <= 4'h0;
            fin_reg    <= 1'b0;
        end else begin
            fin_reg <= 1'b0;
            case (estado_reg)
                LIBRE: begin
                    if (key_valid_i) begin
                        code_reg   <= key_code_i;
                        cnt_reg    <= 16'd0;
                        estado_reg <= primer_estado(REBOTE);
                        fin_reg    <= (primer_estado(REBOTE) == LIBRE);
                    end
                end
                REBOTE: begin
                    if (cnt_reg == REBOTE_FIN) begin
                        cnt_reg    <= 16'd0;
                        estado_reg <= primer_estado(PRESION);
                        fin_reg    <= (primer_estado(PRESION) == LIBRE);
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                PRESION: begin
                    if (cnt_reg == PRESION_FIN) begin
                        cnt_reg    <= 16'd0;
                        estado_reg <= primer_estado(PAUSA);
                        fin_reg    <= (primer_estado(PAUSA) == LIBRE);
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                PAUSA: begin
                    if (cnt_reg == PAUSA_FIN) begin
                        cnt_reg    <= 16'd0;
                        estado_reg <= LIBRE;
                        fin_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin
                    cnt_reg    <= 16'd0;
                    estado_reg <= LIBRE;
                end
            endcase
        end
    end

    // Row lines follow the scanned column combinationally so a column change shows at once.
    assign coincide = (cuenta_i == code_reg[1:0]);
    assign fila     = 4'b0001 << code_reg[3:2];

    always_comb begin
        pulso = 4'b0000;
        case (estado_reg)
            REBOTE:  if (coincide && !cnt_reg[0]) pulso = fila;
            PRESION: if (coincide) pulso = fila;
            default: pulso = 4'b0000;
        endcase
    end

    assign key_ready_o        = (estado_reg == LIBRE);
    assign ocupado_o          = (estado_reg != LIBRE);
    assign pulso_teclas_o     = pulso;
    assign dato_codificador_o = (pulso != 4'b0000) ? code_reg[3:2] : 2'b00;
    assign tecla_fin_o        = fin_reg;

endmodule

// File: tb/tb_emulador_teclado.sv
// Scoreboard bench for emulador_teclado: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the selected instance.
module tb_emulador_teclado;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] cuenta0, cuenta1;
    logic       valid0, valid1;
    logic [3:0] code0, code1;
    logic       ready0, ready1, ocup0, ocup1, fin0, fin1;
    logic [3:0] pulso0, pulso1;
    logic [1:0] dato0, dato1;

    int checks = 0;
    int errors = 0;
    int ph = 0;

    typedef struct {
        int         d;
        logic [3:0] pulso;
        logic [1:0] dato;
        logic       rdy;
        logic       fin;
        string      nm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    emulador_teclado dut0 (
        .clk_i(clk), .reset_i(reset_n), .cuenta_i(cuenta0),
        .key_valid_i(valid0), .key_code_i(code0), .key_ready_o(ready0),
        .pulso_teclas_o(pulso0), .dato_codificador_o(dato0),
        .ocupado_o(ocup0), .tecla_fin_o(fin0)
    );

    emulador_teclado #(.REBOTE_CICLOS(0), .PRESION_CICLOS(8), .PAUSA_CICLOS(0)) dut1 (
        .clk_i(clk), .reset_i(reset_n), .cuenta_i(cuenta1),
        .key_valid_i(valid1), .key_code_i(code1), .key_ready_o(ready1),
        .pulso_teclas_o(pulso1), .dato_codificador_o(dato1),
        .ocupado_o(ocup1), .tecla_fin_o(fin1)
    );

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [8:0] got, req;
            e = sb.pop_front();
            req = {e.rdy, e.pulso, e.dato, ~e.rdy, e.fin};
            if (e.d == 0) got = {ready0, pulso0, dato0, ocup0, fin0};
            else          got = {ready1, pulso1, dato1, ocup1, fin1};
            checks++;
            if (got !== req) begin
                errors++;
                $display("FAIL %s dut%0d t=%0t: got rdy/pulso/dato/ocup/fin=%b required %b",
                         e.nm, e.d, $time, got, req);
            end
        end
    end

    task automatic step(input int d, input logic v, input logic [3:0] c, input logic [1:0] cu,
                        input logic [3:0] pul, input logic [1:0] dat, input logic rdy,
                        input logic fin, input string nm);
        exp_t e;
        if (d == 0) begin
            valid0 = v; code0 = c; cuenta0 = cu; valid1 = 1'b0;
        end else begin
            valid1 = v; code1 = c; cuenta1 = cu; valid0 = 1'b0;
        end
        e.d = d; e.pulso = pul; e.dato = dat; e.rdy = rdy; e.fin = fin; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ph++;
    endtask

    // One key press from the accept cycle through the last pause cycle.
    task automatic press(input int d, input logic [3:0] code, input bit cyc, input bit first_fin,
                         input logic bv, input logic [3:0] bc, input int r, input int p,
                         input int pa, input int abort_at);
        logic [3:0] oh;
        logic [1:0] cu;
        logic [3:0] pul;
        oh = 4'b0001 << code[3:2];
        cu = cyc ? 2'(ph) : code[1:0];
        step(d, 1'b1, code, cu, 4'b0000, 2'b00, 1'b1, first_fin, "acepta");
        for (int i = 0; i < r; i++) begin
            cu  = cyc ? 2'(ph) : code[1:0];
            pul = (cu == code[1:0] && (i % 2) == 0) ? oh : 4'b0000;
            step(d, bv, bc, cu, pul, (pul != 0) ? code[3:2] : 2'b00, 1'b0, 1'b0, "rebote");
        end
        for (int i = 0; i < p; i++) begin
            cu = cyc ? 2'(ph) : code[1:0];
            if (i == abort_at) begin
                reset_n = 1'b0;
                step(d, 1'b0, 4'h0, cu, 4'b0000, 2'b00, 1'b1, 1'b0, "reset_abort");
                step(d, 1'b0, 4'h0, cu, 4'b0000, 2'b00, 1'b1, 1'b0, "reset_abort");
                reset_n = 1'b1;
                return;
            end
            pul = (cu == code[1:0]) ? oh : 4'b0000;
            step(d, bv, bc, cu, pul, (pul != 0) ? code[3:2] : 2'b00, 1'b0, 1'b0, "presion");
        end
        for (int i = 0; i < pa; i++)
            step(d, bv, bc, code[1:0], 4'b0000, 2'b00, 1'b0, 1'b0, "pausa");
    endtask

    task automatic finish_key(input int d);
        step(d, 1'b0, 4'h0, 2'b00, 4'b0000, 2'b00, 1'b1, 1'b1, "tecla_fin");
        step(d, 1'b0, 4'h0, 2'b00, 4'b0000, 2'b00, 1'b1, 1'b0, "libre");
    endtask

    initial begin
        reset_n = 1'b0;
        valid0 = 1'b0; code0 = 4'h0; cuenta0 = 2'b00;
        valid1 = 1'b0; code1 = 4'h0; cuenta1 = 2'b00;
        @(posedge clk);
        #1;
        step(0, 1'b1, 4'h9, 2'b01, 4'b0000, 2'b00, 1'b1, 1'b0, "reset_ini");
        step(1, 1'b1, 4'h9, 2'b01, 4'b0000, 2'b00, 1'b1, 1'b0, "reset_ini");
        reset_n = 1'b1;

        // Defaults, column held matching; accepted on first edge after reset.
        press(0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h0, 4, 64, 16, -1);
        finish_key(0);

        // Column scan cycling 0..3.
        press(0, 4'h9, 1'b1, 1'b0, 1'b0, 4'h0, 4, 64, 16, -1);
        finish_key(0);

        // Second key offered while busy, accepted in the tecla_fin cycle.
        press(0, 4'h9, 1'b0, 1'b0, 1'b1, 4'h3, 4, 64, 16, -1);
        press(0, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 4, 64, 16, -1);
        finish_key(0);

        // Reset at PRESION cycle 30, then an immediate new acceptance.
        press(0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h0, 4, 64, 16, 30);
        press(0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h0, 4, 64, 16, -1);
        finish_key(0);

        // Back-to-back F then 0 with valid held high.
        press(0, 4'hF, 1'b0, 1'b0, 1'b1, 4'h0, 4, 64, 16, -1);
        press(0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4, 64, 16, -1);
        finish_key(0);

        // Skipped bounce and pause states.
        press(1, 4'h6, 1'b0, 1'b0, 1'b0, 4'h0, 0, 8, 0, -1);
        finish_key(1);
        press(1, 4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 0, 8, 0, -1);
        finish_key(1);

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
